collatz_batch_engine: RTL and testbench

//  Computes Collatz iteration counts for RAM_WORDS consecutive start values and stores them in on-chip RAM.

---
 rtl/collatz_pkg.sv | 22 ++
 rtl/collatz_batch_engine_if.sv | 24 ++
 rtl/collatz_iter.sv | 45 ++++
 rtl/collatz_batch_engine.sv | 85 ++++++++
 tb/tb_collatz_batch_engine.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/collatz_pkg.sv
// Shared types and widths for the Collatz batch engine: FSM states, datapath widths
// and the single-step Collatz function used by the iteration datapath.
package collatz_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        STEP,
        WRITE,
        DONE
    } state_t;

    localparam int N_W = 32;
    localparam int COUNT_W = 16;
    localparam logic [COUNT_W-1:0] COUNT_MAX = 16'hFFFF;

    // 3n+1 wraps modulo 2^N_W; overflow is deliberately not flagged.
    function automatic logic [N_W-1:0] collatz_next(input logic [N_W-1:0] n);
        return n[0] ? (n + (n << 1) + N_W'(1)) : (n >> 1);
    endfunction

endpackage

// File: rtl/collatz_batch_engine_if.sv
// Control/result bus between the lab1 control logic (master) and the batch engine (slave).
interface collatz_batch_engine_if;
    import collatz_pkg::*;

    logic               go;
    logic [N_W-1:0]     start;
    logic               done;
    logic [COUNT_W-1:0] count;

    modport master (
        output go,
        output start,
        input  done,
        input  count
    );

    modport slave (
        input  go,
        input  start,
        output done,
        output count
    );

endinterface

// File: rtl/collatz_iter.sv
// Holds n and the term counter for one start value; loads on 'load', then steps once per
// clock until the sequence reaches 1 or the counter saturates.
module collatz_iter
    import collatz_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [N_W-1:0]     n_in,
    output logic               busy,
    output logic [COUNT_W-1:0] cnt_out
);

    logic [N_W-1:0]     n;
    logic [N_W-1:0]     n_next;
    logic [COUNT_W-1:0] cnt_next;
    logic               active;
    logic               last;

    // busy drops during the step that produces the final term, so the sequencer
    // can move to WRITE on the same edge without an idle cycle.
    always_comb begin
        n_next   = collatz_next(n);
        cnt_next = (cnt_out == COUNT_MAX) ? COUNT_MAX : cnt_out + 1'b1;
        last     = (n_next == N_W'(1)) || (cnt_next == COUNT_MAX);
        busy     = active & ~last;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            n       <= '0;
            cnt_out <= '0;
            active  <= 1'b0;
        end else if (load) begin
            n       <= n_in;
            cnt_out <= (n_in == '0) ? '0 : COUNT_W'(1);
            active  <= (n_in > N_W'(1));
        end else if (active) begin
            n       <= n_next;
            cnt_out <= cnt_next;
            active  <= ~last;
        end
    end

endmodule

// File: rtl/collatz_batch_engine.sv
// Computes Collatz term counts for RAM_WORDS consecutive start values into block RAM,
// then serves them through a registered read port while done is high.
module collatz_batch_engine
    import collatz_pkg::*;
#(
    parameter int RAM_WORDS     = 256,
    parameter int RAM_ADDR_BITS = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    collatz_batch_engine_if.slave bus
);

    localparam logic [RAM_ADDR_BITS-1:0] LAST_IDX = RAM_ADDR_BITS'(RAM_WORDS - 1);

    state_t                   state;
    logic [N_W-1:0]           base;
    logic [RAM_ADDR_BITS-1:0] idx;
    logic [N_W-1:0]           n_start;
    logic                     load;
    logic                     iter_busy;
    logic [COUNT_W-1:0]       iter_cnt;
    logic [COUNT_W-1:0]       ram [RAM_WORDS];

    assign n_start = base + N_W'(idx);
    assign load    = (state == LOAD);

    collatz_iter u_iter (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .n_in    (n_start),
        .busy    (iter_busy),
        .cnt_out (iter_cnt)
    );

    // Start values 0 and 1 need no iteration, so LOAD skips STEP for them.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            base     <= '0;
            idx      <= '0;
            bus.done <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.go) begin
                        base     <= bus.start;
                        idx      <= '0;
                        bus.done <= 1'b0;
                        state    <= LOAD;
                    end
                end
                LOAD: state <= (n_start > N_W'(1)) ? STEP : WRITE;
                STEP: begin
                    if (!iter_busy) state <= WRITE;
                end
                WRITE: begin
                    if (idx == LAST_IDX) begin
                        state    <= DONE;
                        bus.done <= 1'b1;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= LOAD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == WRITE) ram[idx] <= iter_cnt;
    end

    // Read register with synchronous reset; holds its value outside DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.count <= '0;
        end else if (state == DONE) begin
            bus.count <= ram[bus.start[RAM_ADDR_BITS-1:0]];
        end
    end

endmodule

// File: tb/tb_collatz_batch_engine.sv
// Self-checking bench for collatz_batch_engine: directed scenarios plus random batches,
// checked against an arithmetic Collatz model of every word and of total batch latency.
module tb_collatz_batch_engine;

    localparam int WORDS = 8;
    localparam int ABITS = 3;

    logic clk = 1'b0;
    logic reset;
    int   compared = 0;
    int   mismatched = 0;
    int   exp_ram [WORDS];

    collatz_batch_engine_if bus ();

    collatz_batch_engine #(
        .RAM_WORDS     (WORDS),
        .RAM_ADDR_BITS (ABITS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #10 clk = ~clk;

    // Number of terms from v down to 1, arithmetic modulo 2^32, saturating at 65535.
    function automatic int model_count(input logic [31:0] v);
        logic [31:0] n;
        int c;
        if (v == 32'd0) return 0;
        n = v;
        c = 1;
        while (n != 32'd1 && c != 65535) begin
            if (n[0]) n = 3 * n + 1;
            else      n = n / 2;
            c++;
        end
        return c;
    endfunction

    // Fills the expected RAM image and returns go-edge-to-done latency in cycles.
    function automatic int model_batch(input logic [31:0] b);
        int s;
        s = 0;
        for (int i = 0; i < WORDS; i++) begin
            exp_ram[i] = model_count(b + 32'(i));
            s += ((exp_ram[i] < 1) ? 1 : exp_ram[i]) + 1;
        end
        return s;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic g, input logic [31:0] s);
        bus.go    = g;
        bus.start = s;
        @(posedge clk);
        @(negedge clk);
        bus.go = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic runBatch(input logic [31:0] b, input bit inject, input string tag);
        int s;
        int k;
        s = model_batch(b);
        applyStimulus(1'b1, b);
        checkOutput({tag, "_done_drop"}, 32'(bus.done), 32'd0);
        k = 0;
        while (bus.done !== 1'b1 && k < s + 16) begin
            if (inject && (k == 2 || k == 5 || k == 9 || k == 20)) begin
                bus.go    = 1'b1;
                bus.start = $urandom;
            end else begin
                bus.go = 1'b0;
            end
            tick();
            k++;
        end
        bus.go = 1'b0;
        checkOutput({tag, "_cycles"}, 32'(k), 32'(s));
    endtask

    task automatic readSweep(input int n, input bit seq, input string tag);
        logic [31:0] s;
        int a;
        int prev;
        a = seq ? 0 : int'($urandom_range(0, WORDS - 1));
        s = $urandom;
        s[ABITS-1:0] = a[ABITS-1:0];
        bus.start = s;
        tick();
        for (int i = 1; i <= n; i++) begin
            prev = a;
            checkOutput($sformatf("%s_addr%0d", tag, prev), 32'(bus.count), 32'(exp_ram[prev]));
            if (i < n) begin
                a = seq ? (i % WORDS) : int'($urandom_range(0, WORDS - 1));
                s = $urandom;
                s[ABITS-1:0] = a[ABITS-1:0];
                bus.start = s;
                tick();
            end
        end
        checkOutput({tag, "_done_held"}, 32'(bus.done), 32'd1);
    endtask

    initial begin
        logic [31:0] b;
        int s;

        reset     = 1'b1;
        bus.go    = 1'b0;
        bus.start = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        checkOutput("reset_done", 32'(bus.done), 32'd0);
        checkOutput("reset_count", 32'(bus.count), 32'd0);
        repeat (3) tick();
        checkOutput("idle_no_go", 32'(bus.done), 32'd0);

        $display("[TB] batch from 1");
        runBatch(32'd1, 1'b0, "s1");
        exp_ram = '{1, 2, 8, 3, 6, 9, 17, 4};
        readSweep(WORDS, 1'b1, "s1_read");

        $display("[TB] batch from 1 with go pulses during the run");
        runBatch(32'd1, 1'b1, "s3");
        readSweep(WORDS, 1'b1, "s3_read");

        $display("[TB] batch from 27");
        runBatch(32'd27, 1'b0, "s2");
        bus.start = 32'hABCD_0000;
        tick();
        checkOutput("s2_count27", 32'(bus.count), 32'h0070);
        readSweep(24, 1'b0, "s6_sweep");

        $display("[TB] reset in the middle of a batch");
        applyStimulus(1'b1, 32'd27);
        repeat (30) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("s4_done", 32'(bus.done), 32'd0);
        checkOutput("s4_count", 32'(bus.count), 32'd0);
        repeat (4) tick();
        checkOutput("s4_idle", 32'(bus.done), 32'd0);
        runBatch(32'd3, 1'b0, "s4_rerun");
        readSweep(WORDS, 1'b1, "s4_read");

        $display("[TB] batch from 0");
        runBatch(32'd0, 1'b0, "s5_zero");
        readSweep(WORDS, 1'b1, "s5_zero_read");

        for (int r = 0; r < 3; r++) begin
            b = $urandom_range(2, 100000);
            $display("[TB] random batch from %0d", b);
            runBatch(b, 1'b0, $sformatf("rand%0d", r));
            readSweep(12, 1'b0, $sformatf("rand%0d_read", r));
        end

        b = 32'hFFFF_FFFC;
        s = model_batch(b);
        if (s < 10000) begin
            $display("[TB] batch wrapping through 2^32");
            runBatch(b, 1'b0, "s5_wrap");
            readSweep(WORDS, 1'b1, "s5_wrap_read");
        end else begin
            $display("[TB] wrap batch skipped, model latency %0d cycles", s);
        end

        // 0x55555555 becomes 0 after one 3n+1 step, so its count must saturate.
        b = 32'h5555_5550;
        s = model_batch(b);
        if (s < 75000) begin
            $display("[TB] overflow and saturation batch");
            runBatch(b, 1'b0, "s5_sat");
            readSweep(WORDS, 1'b1, "s5_sat_read");
        end else begin
            $display("[TB] saturation batch skipped, model latency %0d cycles", s);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
